// File: rtl/fetch_stage.sv
// Instruction fetch stage: boots the PC from a memory vector, assembles two-word
// instructions, handles redirects and stalls, and vectors interrupts.
module fetch_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             stall,
    input  logic             fetch_pc_enable,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      pc_jmp,
    input  logic [31:0]      mem_pc,
    input  logic             interrupt,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] imm_out,
    output logic [31:0]      pc_out,
    output logic             valid_out,
    output logic             int_req,
    output logic [31:0]      int_pc
);

    typedef enum logic [2:0] {
        BOOT_LO = 3'd0,
        BOOT_HI = 3'd1,
        RUN     = 3'd2,
        IMM     = 3'd3,
        INT_LO  = 3'd4,
        INT_HI  = 3'd5
    } state_t;

    state_t           state_r;
    logic [31:0]      pc_r;
    logic [15:0]      half_r;
    logic [WIDTH-1:0] word_r;
    logic             int_pending_r;

    logic             redirect_s;
    logic [31:0]      target_s;
    logic [31:0]      pc_inc_s;
    logic             int_take_s;

    function automatic logic is_two_word(input logic [WIDTH-1:0] w);
        logic [4:0] op;
        op = w[WIDTH-1:WIDTH-5];
        case (op)
            5'b10100, 5'b10110, 5'b10111: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Memory address: fixed vector words during boot/interrupt entry, PC otherwise.
    always_comb begin
        case (state_r)
            BOOT_LO: imem_addr = 32'd0;
            BOOT_HI: imem_addr = 32'd1;
            INT_LO:  imem_addr = 32'd2;
            INT_HI:  imem_addr = 32'd3;
            default: imem_addr = pc_r;
        endcase
    end

    // Redirect decode, sequential PC and interrupt-acceptance qualifiers.
    always_comb begin
        case (pc_sel)
            2'b01: begin
                redirect_s = fetch_pc_enable;
                target_s   = pc_jmp;
            end
            2'b10: begin
                redirect_s = fetch_pc_enable;
                target_s   = mem_pc;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = pc_r;
            end
        endcase
        pc_inc_s = pc_r + 32'd1;
        if (state_r == RUN) begin
            int_take_s = int_pending_r | interrupt;
        end else begin
            int_take_s = 1'b0;
        end
    end

    // Fetch FSM with registered IF/ID outputs; a request arriving this cycle is takeable now.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT_LO;
            pc_r          <= 32'd0;
            half_r        <= 16'd0;
            word_r        <= '0;
            int_pending_r <= 1'b0;
            instr_out     <= '0;
            imm_out       <= '0;
            pc_out        <= 32'd0;
            valid_out     <= 1'b0;
            int_req       <= 1'b0;
            int_pc        <= 32'd0;
        end else begin
            int_req <= 1'b0;
            if (interrupt) begin
                int_pending_r <= 1'b1;
            end
            case (state_r)
                BOOT_LO, INT_LO: begin
                    half_r    <= imem_data[15:0];
                    instr_out <= '0;
                    imm_out   <= '0;
                    valid_out <= 1'b0;
                    state_r   <= (state_r == BOOT_LO) ? BOOT_HI : INT_HI;
                end
                BOOT_HI, INT_HI: begin
                    pc_r      <= {half_r, imem_data[15:0]};
                    instr_out <= '0;
                    imm_out   <= '0;
                    valid_out <= 1'b0;
                    state_r   <= RUN;
                end
                RUN, IMM: begin
                    if (stall) begin
                        state_r <= state_r;
                    end else if (redirect_s) begin
                        pc_r      <= target_s;
                        instr_out <= '0;
                        imm_out   <= '0;
                        valid_out <= 1'b0;
                        state_r   <= RUN;
                    end else if (!fetch_pc_enable) begin
                        instr_out <= '0;
                        imm_out   <= '0;
                        valid_out <= 1'b0;
                    end else if (int_take_s) begin
                        int_pc        <= pc_r;
                        int_req       <= 1'b1;
                        int_pending_r <= 1'b0;
                        instr_out     <= '0;
                        imm_out       <= '0;
                        valid_out     <= 1'b0;
                        state_r       <= INT_LO;
                    end else if (state_r == IMM) begin
                        instr_out <= word_r;
                        imm_out   <= imem_data;
                        pc_out    <= pc_inc_s;
                        valid_out <= 1'b1;
                        pc_r      <= pc_inc_s;
                        state_r   <= RUN;
                    end else if (is_two_word(imem_data)) begin
                        word_r    <= imem_data;
                        pc_r      <= pc_inc_s;
                        instr_out <= '0;
                        imm_out   <= '0;
                        valid_out <= 1'b0;
                        state_r   <= IMM;
                    end else begin
                        instr_out <= imem_data;
                        imm_out   <= '0;
                        pc_out    <= pc_inc_s;
                        valid_out <= 1'b1;
                        pc_r      <= pc_inc_s;
                    end
                end
                default: begin
                    state_r <= BOOT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a cycle model of fetch behaviour checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        fetch_pc_enable;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jmp;
    logic [31:0] mem_pc;
    logic        interrupt;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        int_req;
    logic [31:0] int_pc;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .fetch_pc_enable(fetch_pc_enable), .pc_sel(pc_sel),
        .pc_jmp(pc_jmp), .mem_pc(mem_pc), .interrupt(interrupt),
        .instr_out(instr_out), .imm_out(imm_out), .pc_out(pc_out),
        .valid_out(valid_out), .int_req(int_req), .int_pc(int_pc)
    );

    // Memory: low 512 words from the table, everything else reads {8'h00, addr[7:0]}.
    logic [15:0] mem [0:511];
    always_comb imem_data = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : {8'h00, imem_addr[7:0]};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rd(input logic [31:0] a);
        if (a < 32'd512) return mem[a[8:0]];
        return {8'h00, a[7:0]};
    endfunction

    function automatic bit two_word(input logic [15:0] w);
        return (w[15:11] == 5'b10100) || (w[15:11] == 5'b10110) || (w[15:11] == 5'b10111);
    endfunction

    // Model: vector words still to read, a "first half in hand" flag, and plain PC arithmetic.
    bit          live = 1'b0;
    logic [31:0] m_pc, vec_base, e_pcout, e_intpc;
    logic [15:0] m_hi, first_word, e_instr, e_imm, w;
    int          boot_left;
    bit          have_first, pending, e_valid, e_intreq;

    function automatic logic [31:0] m_addr();
        if (boot_left > 0) return vec_base + 32'(2 - boot_left);
        return m_pc;
    endfunction

    task automatic m_bubble();
        e_instr = 16'h0; e_imm = 16'h0; e_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            live = 1'b1; m_pc = 32'h0; vec_base = 32'h0; boot_left = 2;
            have_first = 1'b0; pending = 1'b0; m_hi = 16'h0; first_word = 16'h0;
            m_bubble(); e_pcout = 32'h0; e_intreq = 1'b0; e_intpc = 32'h0;
        end else if (live) begin
            w = rd(m_addr());
            e_intreq = 1'b0;
            if (interrupt) pending = 1'b1;
            if (boot_left > 0) begin
                m_bubble();
                if (boot_left == 2) m_hi = w;
                else m_pc = {m_hi, w};
                boot_left--;
            end else if (stall) begin
                have_first = have_first;
            end else if (fetch_pc_enable && (pc_sel == 2'b01 || pc_sel == 2'b10)) begin
                m_pc = (pc_sel == 2'b01) ? pc_jmp : mem_pc;
                have_first = 1'b0;
                m_bubble();
            end else if (!fetch_pc_enable) begin
                m_bubble();
            end else if (!have_first && pending) begin
                e_intpc = m_pc; e_intreq = 1'b1; pending = 1'b0;
                boot_left = 2; vec_base = 32'd2;
                m_bubble();
            end else if (have_first) begin
                m_pc = m_pc + 32'd1;
                e_instr = first_word; e_imm = w; e_pcout = m_pc; e_valid = 1'b1;
                have_first = 1'b0;
            end else if (two_word(w)) begin
                first_word = w; have_first = 1'b1; m_pc = m_pc + 32'd1;
                m_bubble();
            end else begin
                m_pc = m_pc + 32'd1;
                e_instr = w; e_imm = 16'h0; e_pcout = m_pc; e_valid = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (live) begin
            chk("imem_addr", imem_addr, m_addr());
            chk("instr_out", {16'h0, instr_out}, {16'h0, e_instr});
            chk("imm_out", {16'h0, imm_out}, {16'h0, e_imm});
            chk("pc_out", pc_out, e_pcout);
            chk("valid_out", {31'h0, valid_out}, {31'h0, e_valid});
            chk("int_req", {31'h0, int_req}, {31'h0, e_intreq});
            chk("int_pc", int_pc, e_intpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_pc_enable = 1'b1; pc_sel = 2'b00;
        pc_jmp = 32'h0; mem_pc = 32'h0; interrupt = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = {8'h00, 8'(i)};
        mem[0] = 16'h0000; mem[1] = 16'h0020; mem[2] = 16'h0000; mem[3] = 16'h0100;
        mem[9'h020] = 16'hA000; mem[9'h021] = 16'h1234; mem[9'h023] = 16'hB8AA;
        mem[9'h100] = 16'hA0F0; mem[9'h101] = 16'h5555;
        tick(); tick();
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", {16'h0, instr_out}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_int_pc", int_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        // Boot vector then two-word LDM at 0x20
        tick(); chk("boot_addr1", imem_addr, 32'h1);
        tick(); chk("boot_addr20", imem_addr, 32'h20);
        chk("boot_no_issue", {31'h0, valid_out}, 32'h0);
        tick(); chk("ldm_bubble", {31'h0, valid_out}, 32'h0);
        tick();
        chk("ldm_instr", {16'h0, instr_out}, 32'hA000);
        chk("ldm_imm", {16'h0, imm_out}, 32'h1234);
        chk("ldm_pc_out", pc_out, 32'h22);
        chk("ldm_valid", {31'h0, valid_out}, 32'h1);
        tick(); chk("seq_instr", {16'h0, instr_out}, 32'h0022);
        // Redirect while the second word of 0xB8AA is pending
        tick(); pc_sel = 2'b01; pc_jmp = 32'h40;
        tick(); chk("redir_imm_valid", {31'h0, valid_out}, 32'h0);
        chk("redir_imm_addr", imem_addr, 32'h40);
        pc_sel = 2'b10; mem_pc = 32'h25;
        tick(); pc_sel = 2'b00;
        tick(); chk("pre_stall_instr", {16'h0, instr_out}, 32'h0025);
        // Three stall cycles must freeze everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h26);
            chk("stall_pc_out", pc_out, 32'h26);
            chk("stall_instr", {16'h0, instr_out}, 32'h0025);
        end
        stall = 1'b0;
        tick(); chk("resume_pc_out", pc_out, 32'h27);
        // PC hold, with an ignored redirect while disabled, then pc_sel=11 as sequential
        fetch_pc_enable = 1'b0;
        tick(); pc_sel = 2'b01; pc_jmp = 32'h77;
        tick(); chk("hold_valid", {31'h0, valid_out}, 32'h0);
        chk("hold_addr", imem_addr, 32'h27);
        fetch_pc_enable = 1'b1; pc_sel = 2'b11;
        tick(); chk("sel11_pc_out", pc_out, 32'h28);
        // Interrupt at PC 0x30
        pc_sel = 2'b01; pc_jmp = 32'h30;
        tick(); pc_sel = 2'b00; interrupt = 1'b1;
        tick(); interrupt = 1'b0;
        chk("int_req", {31'h0, int_req}, 32'h1);
        chk("int_pc", int_pc, 32'h30);
        chk("int_addr2", imem_addr, 32'h2);
        tick(); chk("int_req_pulse", {31'h0, int_req}, 32'h0);
        chk("int_addr3", imem_addr, 32'h3);
        tick(); chk("isr_addr", imem_addr, 32'h100);
        // Interrupt raised during a stalled IMM waits for the pair to issue
        tick(); stall = 1'b1; interrupt = 1'b1;
        tick(); stall = 1'b0; interrupt = 1'b0;
        chk("imm_int_defer", {31'h0, int_req}, 32'h0);
        tick();
        chk("imm_pair_instr", {16'h0, instr_out}, 32'hA0F0);
        chk("imm_pair_imm", {16'h0, imm_out}, 32'h5555);
        tick();
        chk("imm_int_req", {31'h0, int_req}, 32'h1);
        chk("imm_int_pc", int_pc, 32'h102);
        tick(); tick();
        // PC wrap from 0xFFFFFFFF
        pc_sel = 2'b01; pc_jmp = 32'hFFFF_FFFF;
        tick(); pc_sel = 2'b00;
        tick();
        chk("wrap_pc_out", pc_out, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_instr", {16'h0, instr_out}, 32'h00FF);
        tick();
        // Reset in the middle of an IMM sequence
        pc_sel = 2'b01; pc_jmp = 32'h20;
        tick(); pc_sel = 2'b00;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc_out", pc_out, 32'h0);
        tick(); tick();
        chk("reboot_addr", imem_addr, 32'h20);
        tick(); tick(); tick();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction-word width; PC fixed at 32 bits.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- imem_addr  out  32  instruction-memory word address; combinational from state/PC
- imem_data  in  WIDTH  memory word at imem_addr, same cycle
- stall  in  1  hold stage (load-use or CU freeze)
- fetch_pc_enable  in  1  0 = hold PC, issue bubble
- pc_sel  in  2  00 sequential, 01 pc_jmp, 10 mem_pc, 11 treated as 00
- pc_jmp  in  32  branch/call target
- mem_pc  in  32  popped return PC (RET/RTI)
- interrupt  in  1  interrupt request pulse
- instr_out  out  WIDTH  IF/ID instruction register
- imm_out  out  WIDTH  IF/ID immediate word
- pc_out  out  32  address after last word of issued instruction
- valid_out  out  1  IF/ID holds a real instruction
- int_req  out  1  one-cycle pulse: interrupt taken, push int_pc/CCR
- int_pc  out  32  return address for the taken interrupt

Function
REQ-003 SHALL implement FSM states BOOT_LO, BOOT_HI, RUN, IMM, INT_LO, INT_HI.
REQ-004 BOOT_LO: imem_addr=0, latch imem_data as PC[31:16]; -> BOOT_HI.
REQ-005 BOOT_HI: imem_addr=1, PC <= {latched, imem_data}; -> RUN; no issue in either boot state.
REQ-006 Bubble SHALL mean instr_out=0, imm_out=0, valid_out=0; pc_out unchanged.
REQ-007 RUN/IMM: imem_addr=PC.
REQ-008 Priority each RUN/IMM cycle: stall > redirect > fetch_pc_enable=0 > interrupt > normal.
REQ-009 stall=1: PC, state, and all IF/ID outputs hold.
REQ-010 Redirect (pc_sel 01/10 with fetch_pc_enable=1): PC <= target, bubble issued, IMM aborted -> RUN.
REQ-011 fetch_pc_enable=0 (no stall): PC holds, bubble issued.
REQ-012 Normal RUN, single-word: instr_out<=imem_data, imm_out<=0, pc_out<=PC+1, valid_out<=1, PC<=PC+1.
REQ-013 Two-word opcodes (imem_data[WIDTH-1:WIDTH-5] in {10100, 10110, 10111}): latch word internally, PC<=PC+1, bubble, -> IMM.
REQ-014 IMM: instr_out<=latched word, imm_out<=imem_data, pc_out<=PC+1, valid_out<=1, PC<=PC+1, -> RUN.
REQ-015 interrupt=1 in any non-reset cycle SHALL set int_pending; held until taken.
REQ-016 Interrupt taken only in RUN with no stall/redirect and fetch_pc_enable=1: int_pc<=PC, int_req<=1 for one cycle, bubble, clear pending, -> INT_LO; never taken in IMM or boot.
REQ-017 INT_LO: imem_addr=2, latch high half; INT_HI: imem_addr=3, PC<={high, imem_data}, -> RUN; both issue bubbles; stall is ignored.
REQ-018 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0.

Reset
REQ-019 rst=1 at clock edge: state<=BOOT_LO, PC=0, instr_out=0, imm_out=0, pc_out=0, valid_out=0, int_req=0, int_pc=0, int_pending=0.
REQ-020 rst mid-operation, including IMM and INT states, SHALL discard all progress; boot restarts from address 0.

Verification
REQ-021 Boot: M[0]=0x0000, M[1]=0x0020, release rst -> imem_addr 0,1, then 0x20; first valid_out at cycle 3.
REQ-022 Two-word: M[0x20]=0xA000 (LDM), M[0x21]=0x1234 -> one bubble, then instr_out=0xA000, imm_out=0x1234, pc_out=0x22, valid_out=1.
REQ-023 Redirect in IMM: pc_sel=01, pc_jmp=0x40 during IMM -> bubble, no imm issue, next imem_addr=0x40.
REQ-024 Stall: stall=1 for 3 cycles after issue at 0x25 -> outputs and imem_addr constant; resumes at 0x26.
REQ-025 Interrupt: pulse at PC=0x30, M[2]=0x0000, M[3]=0x0100 -> int_req one cycle, int_pc=0x30, then imem_addr 2, 3, 0x100.
REQ-026 Interrupt during IMM -> taken only after instruction pair issues; int_pc = address after imm word.
